// File: rtl/timer_pkg.sv
// Shared register offsets, ctrl bit positions and the mtime type for the
// machine timer.
package timer_pkg;

  typedef logic [63:0] mtime_t;

  localparam logic [4:0] MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] CTRL        = 5'h10;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_IRQ_BIT = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the core clock into mtime ticks; the counter and tick both freeze
// while enable is low.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == CW'(PRESCALE - 1));
  assign tick = enable && last;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped mtime/mtimecmp pair with a registered level interrupt and a
// single-cycle-latency 32-bit bus slave.
module machine_timer
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1,
  parameter mtime_t      CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        bus_err,
  output logic [63:0] mtime,
  output logic        timer_irq
);

  mtime_t      mtime_q, mtime_d;
  mtime_t      cmp_q, cmp_d;
  logic        en_q, en_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        bus_err_q, bus_err_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic [4:0]  off;
  logic        mapped;

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (en_q),
    .tick   (tick)
  );

  assign off    = addr & 5'b11100;
  assign mapped = (off <= CTRL);

  always_comb begin
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d       = cmp_q;
    en_d        = en_q;
    hi_shadow_d = hi_shadow_q;
    rdata_d     = '0;
    rvalid_d    = re;
    bus_err_d   = (re || we) && !mapped;
    irq_d       = (mtime_q >= cmp_q);

    // Reads see pre-write register values when re and we coincide.
    if (re) begin
      case (off)
        MTIME_LO: begin
          rdata_d     = mtime_q[31:0];
          hi_shadow_d = mtime_q[63:32];
        end
        MTIME_HI:    rdata_d = hi_shadow_q;
        MTIMECMP_LO: rdata_d = cmp_q[31:0];
        MTIMECMP_HI: rdata_d = cmp_q[63:32];
        CTRL: begin
          rdata_d[CTRL_EN_BIT]  = en_q;
          rdata_d[CTRL_IRQ_BIT] = irq_q;
        end
        default:     rdata_d = '0;
      endcase
    end

    // A software write to either mtime half wins over the increment.
    if (we) begin
      case (off)
        MTIME_LO:    mtime_d = {mtime_q[63:32], wdata};
        MTIME_HI:    mtime_d = {wdata, mtime_q[31:0]};
        MTIMECMP_LO: cmp_d   = {cmp_q[63:32], wdata};
        MTIMECMP_HI: cmp_d   = {wdata, cmp_q[31:0]};
        CTRL:        en_d    = wdata[CTRL_EN_BIT];
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q     <= '0;
      cmp_q       <= CMP_RESET;
      en_q        <= 1'b1;
      hi_shadow_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      en_q        <= en_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      bus_err_q   <= bus_err_d;
      irq_q       <= irq_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign bus_err   = bus_err_q;
  assign mtime     = mtime_q;
  assign timer_irq = irq_q;

endmodule
